eth_tx_arb: RTL and testbench

Round-robin scheduler that shares one eth_tx pipe between REQ_N application requesters. It takes early packet requests, grants the pipe to one requester per packet, and latches that packet's length and checksum. It muxes the granted requester's data stream onto the eth_tx application interface and counts payload bytes to find the end of the packet. It enforces an inter-packet gap and a stall watchdog, and it sits directly between the application ports and eth_tx.

---
 rtl/eth_tx_arb.sv | 191 +++++++++++++++++++
 tb/tb_eth_tx_arb.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arb.sv
// Round-robin scheduler that shares one eth_tx pipe between REQ_N requesters.
// It grants one packet at a time, counts payload bytes, and enforces an inter-packet gap and a stall watchdog.
module eth_tx_arb #(
    parameter int REQ_N     = 4,
    parameter int IDX_W     = $clog2(REQ_N),
    parameter int DATA_W    = 16,
    parameter int KEEP_W    = DATA_W / 8,
    parameter int LEN_W     = $clog2(KEEP_W + 1),
    parameter int PKT_LEN_W = 16,
    parameter int UDP_CS_W  = 16,
    parameter int GAP_CYC   = 4,
    parameter int TO_CYC    = 64
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic [REQ_N-1:0]              req_early_v_i,
    input  logic [REQ_N-1:0]              req_cancel_i,
    input  logic [REQ_N*PKT_LEN_W-1:0]    req_pkt_len_i,
    input  logic [REQ_N*UDP_CS_W-1:0]     req_cs_i,
    input  logic [REQ_N-1:0]              req_valid_i,
    input  logic [REQ_N*DATA_W-1:0]       req_data_i,
    input  logic [REQ_N*LEN_W-1:0]        req_len_i,
    output logic [REQ_N-1:0]              req_grant_o,
    output logic [REQ_N-1:0]              req_ready_v_o,
    output logic                          tx_early_v_o,
    output logic                          tx_cancel_o,
    output logic [PKT_LEN_W-1:0]          tx_pkt_len_o,
    output logic [UDP_CS_W-1:0]           tx_cs_o,
    output logic                          tx_valid_o,
    output logic [DATA_W-1:0]             tx_data_o,
    output logic [LEN_W-1:0]              tx_len_o,
    input  logic                          tx_ready_v_i,
    output logic                          busy_o,
    output logic [IDX_W-1:0]              grant_idx_o,
    output logic                          timeout_o
);

    localparam int CNT_W = PKT_LEN_W + 1;
    localparam int TO_W  = $clog2(TO_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA, S_GAP} state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_rr;
    logic [REQ_N-1:0]       r_grant;
    logic [IDX_W-1:0]       r_grant_idx;
    logic [PKT_LEN_W-1:0]   r_pkt_len;
    logic [UDP_CS_W-1:0]    r_cs;
    logic [CNT_W-1:0]       r_byte_cnt;
    logic [TO_W-1:0]        r_to_cnt;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic                   r_early;

    logic [REQ_N-1:0]       w_elig;
    logic                   w_pick_v;
    logic [IDX_W-1:0]       w_pick_idx;
    logic [IDX_W-1:0]       w_rr_next;
    logic                   w_valid;
    logic [DATA_W-1:0]      w_data;
    logic [LEN_W-1:0]       w_len;
    logic                   w_gcancel;
    logic                   w_timeout;
    logic                   w_cancel;
    logic                   w_accept;
    logic [CNT_W-1:0]       w_byte_next;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [LEN_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W + 1 - LEN_W){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign w_elig = req_early_v_i & ~req_cancel_i;

    // Walk offsets downward so the eligible index closest to r_rr wins.
    always_comb begin
        w_pick_v   = 1'b0;
        w_pick_idx = '0;
        for (int off = REQ_N - 1; off >= 0; off--) begin
            int idx;
            idx = (int'(r_rr) + off) % REQ_N;
            if (w_elig[idx]) begin
                w_pick_v   = 1'b1;
                w_pick_idx = IDX_W'(idx);
            end
        end
    end

    assign w_rr_next = (w_pick_idx == IDX_W'(REQ_N - 1)) ? '0 : w_pick_idx + 1'b1;

    always_comb begin
        w_valid = 1'b0;
        w_data  = '0;
        w_len   = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (r_grant[i]) begin
                w_valid = req_valid_i[i];
                w_data  = req_data_i[i*DATA_W +: DATA_W];
                w_len   = req_len_i[i*LEN_W +: LEN_W];
            end
        end
    end

    assign w_gcancel   = |(r_grant & req_cancel_i);
    assign w_timeout   = (r_state == S_DATA) && (r_to_cnt == TO_W'(TO_CYC));
    assign w_cancel    = (((r_state == S_WAIT) || (r_state == S_DATA)) && w_gcancel) || w_timeout;
    assign w_accept    = (r_state == S_DATA) && w_valid && tx_ready_v_i && !w_cancel;
    assign w_byte_next = sat_add(r_byte_cnt, w_len);

    assign req_grant_o   = r_grant;
    assign req_ready_v_o = (r_state == S_DATA && tx_ready_v_i && !w_cancel) ? r_grant : '0;
    assign tx_early_v_o  = r_early;
    assign tx_cancel_o   = w_cancel;
    assign tx_pkt_len_o  = r_pkt_len;
    assign tx_cs_o       = r_cs;
    assign tx_valid_o    = w_valid;
    assign tx_data_o     = w_data;
    assign tx_len_o      = w_len;
    assign busy_o        = (r_state != S_IDLE);
    assign grant_idx_o   = r_grant_idx;
    assign timeout_o     = w_timeout;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= S_IDLE;
            r_rr        <= '0;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_pkt_len   <= '0;
            r_cs        <= '0;
            r_byte_cnt  <= '0;
            r_to_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_early     <= 1'b0;
        end else begin
            r_early <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_v) begin
                        r_grant     <= REQ_N'(1) << w_pick_idx;
                        r_grant_idx <= w_pick_idx;
                        r_pkt_len   <= req_pkt_len_i[w_pick_idx*PKT_LEN_W +: PKT_LEN_W];
                        r_cs        <= req_cs_i[w_pick_idx*UDP_CS_W +: UDP_CS_W];
                        r_byte_cnt  <= '0;
                        r_rr        <= w_rr_next;
                        r_early     <= 1'b1;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_cancel || (tx_ready_v_i && r_pkt_len == '0)) begin
                        r_grant   <= '0;
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end else if (tx_ready_v_i) begin
                        r_to_cnt <= '0;
                        r_state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_cancel) begin
                        r_grant   <= '0;
                        r_gap_cnt <= '0;
                        r_to_cnt  <= '0;
                        r_state   <= S_GAP;
                    end else if (w_accept) begin
                        r_byte_cnt <= w_byte_next;
                        r_to_cnt   <= '0;
                        if (w_byte_next >= {1'b0, r_pkt_len}) begin
                            r_grant   <= '0;
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: reset, round-robin order, single packet, cancel,
// watchdog, overshoot, zero length and asynchronous reset mid-packet.
module tb_eth_tx_arb;

    localparam int REQ_N = 4;
    localparam int IDX_W = 2;
    localparam int DATA_W = 16;
    localparam int LEN_W = 2;
    localparam int PKT_LEN_W = 16;
    localparam int UDP_CS_W = 16;

    logic                       clk;
    logic                       nreset;
    logic [REQ_N-1:0]           early;
    logic [REQ_N-1:0]           cancel;
    logic [REQ_N*PKT_LEN_W-1:0] pkt_len;
    logic [REQ_N*UDP_CS_W-1:0]  cs;
    logic [REQ_N-1:0]           valid;
    logic [REQ_N*DATA_W-1:0]    data;
    logic [REQ_N*LEN_W-1:0]     len;
    logic                       tx_ready;

    logic [REQ_N-1:0]           grant;
    logic [REQ_N-1:0]           ready_v;
    logic                       tx_early;
    logic                       tx_cancel;
    logic [PKT_LEN_W-1:0]       tx_pkt_len;
    logic [UDP_CS_W-1:0]        tx_cs;
    logic                       tx_valid;
    logic [DATA_W-1:0]          tx_data;
    logic [LEN_W-1:0]           tx_len;
    logic                       busy;
    logic [IDX_W-1:0]           grant_idx;
    logic                       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    eth_tx_arb #(
        .REQ_N(REQ_N), .DATA_W(DATA_W), .PKT_LEN_W(PKT_LEN_W), .UDP_CS_W(UDP_CS_W),
        .GAP_CYC(4), .TO_CYC(8)
    ) dut (
        .clk(clk), .nreset(nreset),
        .req_early_v_i(early), .req_cancel_i(cancel), .req_pkt_len_i(pkt_len), .req_cs_i(cs),
        .req_valid_i(valid), .req_data_i(data), .req_len_i(len),
        .req_grant_o(grant), .req_ready_v_o(ready_v),
        .tx_early_v_o(tx_early), .tx_cancel_o(tx_cancel), .tx_pkt_len_o(tx_pkt_len), .tx_cs_o(tx_cs),
        .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_len_o(tx_len), .tx_ready_v_i(tx_ready),
        .busy_o(busy), .grant_idx_o(grant_idx), .timeout_o(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [15:0] pl, input logic [15:0] c,
                           input logic v, input logic [15:0] d, input logic [1:0] l);
        pkt_len[i*PKT_LEN_W +: PKT_LEN_W] = pl;
        cs[i*UDP_CS_W +: UDP_CS_W]        = c;
        valid[i]                          = v;
        data[i*DATA_W +: DATA_W]          = d;
        len[i*LEN_W +: LEN_W]             = l;
    endtask

    task automatic wait_early(output int cyc);
        cyc = 0;
        do begin
            tick;
            cyc++;
        end while (!tx_early && cyc < 40);
    endtask

    task automatic wait_idle;
        int c;
        c = 0;
        while (busy && c < 30) begin
            tick;
            c++;
        end
        chk("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    int c;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        nreset = 1'b0; early = '0; cancel = '0; pkt_len = '0; cs = '0;
        valid = '0; data = '0; len = '0; tx_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_early", {31'd0, tx_early}, 32'd0);
        chk("rst_idx", {30'd0, grant_idx}, 32'd0);
        chk("rst_pkt_len", {16'd0, tx_pkt_len}, 32'd0);
        chk("rst_cancel", {31'd0, tx_cancel}, 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        tick;

        // Round robin: every requester holds a 2-byte packet
        tx_ready = 1'b1;
        for (int i = 0; i < REQ_N; i++) set_req(i, 16'd2, 16'h0, 1'b1, 16'(i), 2'd2);
        early = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_early(c);
            chk($sformatf("rr_period_%0d", i), c, (i == 0) ? 32'd1 : 32'd7);
            chk($sformatf("rr_idx_%0d", i), {30'd0, grant_idx}, exp_order[i]);
            chk($sformatf("rr_grant_%0d", i), {28'd0, grant}, 32'd1 << exp_order[i]);
        end
        early = '0;
        wait_idle;
        valid = '0;

        // Single request from requester 2, length 6, three 2-byte beats
        tx_ready = 1'b0;
        set_req(2, 16'd6, 16'hBEEF, 1'b0, 16'h0, 2'd2);
        early[2] = 1'b1;
        #1 chk("sr_pre_grant", {28'd0, grant}, 32'd0);
        tick;
        early[2] = 1'b0;
        chk("sr_grant", {28'd0, grant}, 32'b0100);
        chk("sr_early", {31'd0, tx_early}, 32'd1);
        chk("sr_idx", {30'd0, grant_idx}, 32'd2);
        chk("sr_pkt_len", {16'd0, tx_pkt_len}, 32'd6);
        chk("sr_cs", {16'd0, tx_cs}, 32'hBEEF);
        tick;
        chk("sr_early_once", {31'd0, tx_early}, 32'd0);
        chk("sr_wait_hold", {31'd0, busy}, 32'd1);
        tx_ready = 1'b1;
        set_req(2, 16'd6, 16'hBEEF, 1'b1, 16'h1111, 2'd2);
        #1 chk("sr_wait_ready", {28'd0, ready_v}, 32'd0);
        tick;
        for (int b = 0; b < 3; b++) begin
            data[2*DATA_W +: DATA_W] = 16'h1111 * 16'(b + 1);
            #1;
            chk($sformatf("sr_ready_%0d", b), {28'd0, ready_v}, 32'b0100);
            chk($sformatf("sr_data_%0d", b), {16'd0, tx_data}, 32'h1111 * (b + 1));
            tick;
        end
        valid = '0;
        chk("sr_gap_grant", {28'd0, grant}, 32'd0);
        c = 0;
        while (busy && c < 20) begin
            c++;
            tick;
        end
        chk("sr_gap_len", c, 32'd4);
        chk("sr_len_hold", {16'd0, tx_pkt_len}, 32'd6);

        // Cancel from requester 1 after one beat; cancel from requester 3 ignored
        set_req(1, 16'd6, 16'h0, 1'b1, 16'h00A1, 2'd2);
        early[1] = 1'b1;
        tick;
        early[1] = 1'b0;
        chk("cx_grant", {28'd0, grant}, 32'b0010);
        tick;
        cancel[3] = 1'b1;
        #1;
        chk("cx_other_cancel", {31'd0, tx_cancel}, 32'd0);
        chk("cx_beat1_ready", {28'd0, ready_v}, 32'b0010);
        tick;
        cancel[3] = 1'b0;
        cancel[1] = 1'b1;
        #1;
        chk("cx_cancel", {31'd0, tx_cancel}, 32'd1);
        chk("cx_ready_blocked", {28'd0, ready_v}, 32'd0);
        tick;
        cancel[1] = 1'b0;
        chk("cx_gap_grant", {28'd0, grant}, 32'd0);
        chk("cx_gap_busy", {31'd0, busy}, 32'd1);
        wait_idle;
        valid = '0;

        // Watchdog on requester 0 with no valid beats
        set_req(0, 16'd4, 16'h0, 1'b0, 16'h0, 2'd2);
        early[0] = 1'b1;
        tick;
        early[0] = 1'b0;
        tick;
        chk("wd_data_ready", {28'd0, ready_v}, 32'b0001);
        chk("wd_no_timeout", {31'd0, timeout}, 32'd0);
        c = 1;
        while (!timeout && c < 30) begin
            tick;
            c++;
        end
        chk("wd_cycles", c, 32'd9);
        chk("wd_cancel", {31'd0, tx_cancel}, 32'd1);
        tick;
        chk("wd_pulse_end", {31'd0, timeout}, 32'd0);
        chk("wd_gap_grant", {28'd0, grant}, 32'd0);
        wait_idle;

        // Overshoot: length 3 ends after two 2-byte beats on requester 3
        set_req(3, 16'd3, 16'h0, 1'b1, 16'h3333, 2'd2);
        early[3] = 1'b1;
        tick;
        early[3] = 1'b0;
        chk("os_grant", {28'd0, grant}, 32'b1000);
        tick;
        chk("os_beat1", {28'd0, ready_v}, 32'b1000);
        tick;
        chk("os_beat2", {28'd0, ready_v}, 32'b1000);
        tick;
        chk("os_end_grant", {28'd0, grant}, 32'd0);
        chk("os_end_ready", {28'd0, ready_v}, 32'd0);
        valid = '0;
        wait_idle;

        // Zero length on requester 0: WAIT then GAP without any beat
        set_req(0, 16'd0, 16'h0, 1'b1, 16'h0, 2'd2);
        early[0] = 1'b1;
        tick;
        early[0] = 1'b0;
        chk("zl_early", {31'd0, tx_early}, 32'd1);
        chk("zl_wait_ready", {28'd0, ready_v}, 32'd0);
        tick;
        chk("zl_gap_grant", {28'd0, grant}, 32'd0);
        chk("zl_gap_ready", {28'd0, ready_v}, 32'd0);
        chk("zl_gap_busy", {31'd0, busy}, 32'd1);
        valid = '0;
        wait_idle;

        // Asynchronous reset in the middle of a packet from requester 1
        set_req(1, 16'd10, 16'h1234, 1'b1, 16'h5A5A, 2'd2);
        early[1] = 1'b1;
        tick;
        early[1] = 1'b0;
        tick;
        chk("ar_in_data", {28'd0, ready_v}, 32'b0010);
        #1 nreset = 1'b0;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_grant", {28'd0, grant}, 32'd0);
        chk("ar_ready", {28'd0, ready_v}, 32'd0);
        chk("ar_valid", {31'd0, tx_valid}, 32'd0);
        chk("ar_pkt_len", {16'd0, tx_pkt_len}, 32'd0);
        chk("ar_cs", {16'd0, tx_cs}, 32'd0);
        chk("ar_idx", {30'd0, grant_idx}, 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        valid = '0;
        set_req(0, 16'd2, 16'h0, 1'b1, 16'h0, 2'd2);
        set_req(2, 16'd2, 16'h0, 1'b1, 16'h0, 2'd2);
        early[0] = 1'b1;
        early[2] = 1'b1;
        tick;
        early = '0;
        chk("ar_first_grant", {28'd0, grant}, 32'b0001);
        chk("ar_first_idx", {30'd0, grant_idx}, 32'd0);
        chk("ar_first_early", {31'd0, tx_early}, 32'd1);
        wait_idle;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
